// File: rtl/uart_link_pkg.sv
// Shared types and constants for the Arduino UART request scheduler.
// Status codes, scheduler states and frame constants.
package uart_link_pkg;

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_TIMEOUT = 2'd1,
      ST_BADCHK  = 2'd2,
      ST_ALARM   = 2'd3
   } status_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_RX0,
      S_RX1,
      S_CHECK,
      S_RESP
   } state_e;

   localparam logic [7:0] CHK_KEY_DEFAULT = 8'h37;
   localparam logic [7:0] ALARM_CODE      = 8'h00;

   // A reply frame is valid when byte1 is byte0 xor the key.
   function automatic logic frame_ok(
      input logic [7:0] b0,
      input logic [7:0] b1,
      input logic [7:0] key
   );
      return b1 == (b0 ^ key);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester after the pointer.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic          valid
);

   // Scan ptr+1 .. ptr+N (wrapping) and take the first request seen.
   always_comb begin
      int idx;
      gnt   = '0;
      valid = 1'b0;
      idx   = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!valid && req[idx]) begin
            gnt[idx] = 1'b1;
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_req_scheduler.sv
// Shares one UART link among N_REQ requesters: arbitrate, send a byte,
// collect a checked two-byte reply with timeout/retry, return status.
module uart_req_scheduler
   import uart_link_pkg::*;
#(
   parameter int         N_REQ          = 4,
   parameter int         TIMEOUT_CYCLES = 255,
   parameter int         MAX_RETRY      = 2,
   parameter logic [7:0] CHK_KEY        = CHK_KEY_DEFAULT
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   input  logic [8*N_REQ-1:0]       req_code,
   output logic [N_REQ-1:0]         grant,
   output logic                     rsp_valid,
   output logic [$clog2(N_REQ)-1:0] rsp_id,
   output logic [7:0]               rsp_data,
   output logic [1:0]               rsp_status,
   output logic                     alarm,
   input  logic                     alarm_clr,
   output logic [7:0]               tx_data,
   output logic                     tx_wr_en,
   input  logic                     tx_busy,
   input  logic [7:0]               rx_data,
   input  logic                     rx_rdy,
   output logic                     rx_rdy_clr
);

   localparam int         IW   = $clog2(N_REQ);
   localparam logic [15:0] TMO  = 16'(TIMEOUT_CYCLES);
   localparam logic [7:0]  MAXR = 8'(MAX_RETRY);

   state_e           state;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    cur_id;
   logic [7:0]       cur_code;
   logic [7:0]       b0;
   logic [7:0]       b1;
   logic [7:0]       drain_b0;
   logic             drain_have;
   logic [15:0]      timer;
   logic [7:0]       retry;
   logic [N_REQ-1:0] arb_gnt;
   logic             arb_valid;
   logic [IW-1:0]    arb_id;
   logic [7:0]       arb_code;
   logic             rx_take;
   logic             alarm_set;

   rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
      .req   (req),
      .ptr   (ptr),
      .gnt   (arb_gnt),
      .valid (arb_valid)
   );

   // A byte still flagged ready while its clear pulse is out is stale.
   assign rx_take = rx_rdy && !rx_rdy_clr;

   // Encode the one-hot winner and fetch its request byte.
   always_comb begin
      arb_id   = '0;
      arb_code = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_gnt[i]) begin
            arb_id   = IW'(i);
            arb_code = req_code[8*i +: 8];
         end
      end
   end

   // Alarm frames come from a checked reply or an unsolicited pair.
   always_comb begin
      alarm_set = 1'b0;
      if (state == S_CHECK && frame_ok(b0, b1, CHK_KEY) && b0 == ALARM_CODE)
         alarm_set = 1'b1;
      if (state == S_IDLE && rx_take && drain_have &&
          frame_ok(drain_b0, rx_data, CHK_KEY) && drain_b0 == ALARM_CODE)
         alarm_set = 1'b1;
   end

   // Sticky alarm; a set in the same cycle beats a clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         alarm <= 1'b0;
      else if (alarm_set)
         alarm <= 1'b1;
      else if (alarm_clr)
         alarm <= 1'b0;
   end

   // Transaction sequencer with registered link and response outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         ptr        <= IW'(N_REQ - 1);
         cur_id     <= '0;
         cur_code   <= '0;
         b0         <= '0;
         b1         <= '0;
         drain_b0   <= '0;
         drain_have <= 1'b0;
         timer      <= '0;
         retry      <= '0;
         grant      <= '0;
         tx_data    <= '0;
         tx_wr_en   <= 1'b0;
         rx_rdy_clr <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_data   <= '0;
         rsp_status <= ST_OK;
      end else begin
         grant      <= '0;
         tx_wr_en   <= 1'b0;
         rx_rdy_clr <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (rx_take) begin
                  rx_rdy_clr <= 1'b1;
                  if (drain_have) begin
                     drain_have <= 1'b0;
                  end else begin
                     drain_b0   <= rx_data;
                     drain_have <= 1'b1;
                  end
               end
               if (arb_valid) begin
                  cur_id     <= arb_id;
                  cur_code   <= arb_code;
                  retry      <= '0;
                  drain_have <= 1'b0;
                  if (!tx_busy) begin
                     tx_wr_en <= 1'b1;
                     tx_data  <= arb_code;
                     grant    <= arb_gnt;
                     ptr      <= arb_id;
                     timer    <= '0;
                     state    <= S_RX0;
                  end else begin
                     state <= S_SEND;
                  end
               end
            end
            S_SEND: begin
               if (rx_take)
                  rx_rdy_clr <= 1'b1;
               if (!tx_busy) begin
                  tx_wr_en <= 1'b1;
                  tx_data  <= cur_code;
                  if (retry == '0) begin
                     grant[cur_id] <= 1'b1;
                     ptr           <= cur_id;
                  end
                  timer <= '0;
                  state <= S_RX0;
               end
            end
            S_RX0, S_RX1: begin
               if (rx_take) begin
                  rx_rdy_clr <= 1'b1;
                  timer      <= '0;
                  if (state == S_RX0) begin
                     b0    <= rx_data;
                     state <= S_RX1;
                  end else begin
                     b1    <= rx_data;
                     state <= S_CHECK;
                  end
               end else if (timer == TMO) begin
                  rsp_valid  <= 1'b1;
                  rsp_id     <= cur_id;
                  rsp_data   <= '0;
                  rsp_status <= ST_TIMEOUT;
                  state      <= S_RESP;
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            S_CHECK: begin
               if (!frame_ok(b0, b1, CHK_KEY)) begin
                  if (retry < MAXR) begin
                     retry <= retry + 8'd1;
                     state <= S_SEND;
                  end else begin
                     rsp_valid  <= 1'b1;
                     rsp_id     <= cur_id;
                     rsp_data   <= '0;
                     rsp_status <= ST_BADCHK;
                     state      <= S_RESP;
                  end
               end else begin
                  rsp_valid  <= 1'b1;
                  rsp_id     <= cur_id;
                  rsp_data   <= b0;
                  rsp_status <= (b0 == ALARM_CODE) ? ST_ALARM : ST_OK;
                  state      <= S_RESP;
               end
            end
            S_RESP: begin
               rsp_valid  <= 1'b0;
               rsp_id     <= '0;
               rsp_data   <= '0;
               rsp_status <= ST_OK;
               retry      <= '0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_req_scheduler.sv
// Scoreboard bench for uart_req_scheduler with a small UART model.
// Expected link writes and responses are queued, monitors compare.
module tb_uart_req_scheduler;

   logic        clock;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] req_code;
   logic [3:0]  grant;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_data;
   logic [1:0]  rsp_status;
   logic        alarm;
   logic        alarm_clr;
   logic [7:0]  tx_data;
   logic        tx_wr_en;
   logic        tx_busy;
   logic [7:0]  rx_data;
   logic        rx_rdy;
   logic        rx_rdy_clr;

   typedef struct {
      logic [7:0] data;
      logic [3:0] g;
   } tx_exp_t;

   typedef struct {
      logic [1:0] id;
      logic [7:0] data;
      logic [1:0] st;
   } rsp_exp_t;

   tx_exp_t  exp_tx[$];
   rsp_exp_t exp_rsp[$];

   int n_pass = 0;
   int n_total = 0;

   uart_req_scheduler #(
      .N_REQ(4), .TIMEOUT_CYCLES(255), .MAX_RETRY(2), .CHK_KEY(8'h37)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .req        (req),
      .req_code   (req_code),
      .grant      (grant),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_status (rsp_status),
      .alarm      (alarm),
      .alarm_clr  (alarm_clr),
      .tx_data    (tx_data),
      .tx_wr_en   (tx_wr_en),
      .tx_busy    (tx_busy),
      .rx_data    (rx_data),
      .rx_rdy     (rx_rdy),
      .rx_rdy_clr (rx_rdy_clr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] exp);
      n_total++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // Link-write monitor.
   always @(negedge clock) begin
      if (!reset && tx_wr_en) begin
         if (exp_tx.size() == 0) begin
            check("unexpected_tx", {tx_data, grant}, 64'hFFFF);
         end else begin
            tx_exp_t e;
            e = exp_tx.pop_front();
            check("tx_data", tx_data, e.data);
            check("tx_grant", grant, e.g);
         end
      end
   end

   // Response monitor.
   always @(negedge clock) begin
      if (!reset && rsp_valid) begin
         if (exp_rsp.size() == 0) begin
            check("unexpected_rsp", {rsp_id, rsp_data, rsp_status}, 64'hFFFF);
         end else begin
            rsp_exp_t e;
            e = exp_rsp.pop_front();
            check("rsp_id", rsp_id, e.id);
            check("rsp_data", rsp_data, e.data);
            check("rsp_status", rsp_status, e.st);
         end
      end
   end

   task automatic push_tx(input logic [7:0] d, input logic [3:0] g);
      tx_exp_t e;
      e.data = d;
      e.g    = g;
      exp_tx.push_back(e);
   endtask

   task automatic push_rsp(input logic [1:0] id, input logic [7:0] d,
                           input logic [1:0] st);
      rsp_exp_t e;
      e.id   = id;
      e.data = d;
      e.st   = st;
      exp_rsp.push_back(e);
   endtask

   task automatic wait_tx();
      for (int i = 0; i < 60; i++) begin
         @(posedge clock);
         #1;
         if (tx_wr_en) return;
      end
      check("tx_wait_expired", 0, 1);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_rdy  = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(posedge clock);
         #1;
         if (rx_rdy_clr) begin
            rx_rdy = 1'b0;
            return;
         end
      end
      rx_rdy = 1'b0;
      check("rx_clr_wait_expired", 0, 1);
   endtask

   task automatic wait_rsp_done();
      for (int i = 0; i < 1000; i++) begin
         if (exp_rsp.size() == 0) return;
         @(posedge clock);
      end
      check("rsp_wait_expired", exp_rsp.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      check("reset_outputs",
            {grant, tx_wr_en, rsp_valid, rx_rdy_clr, alarm,
             tx_data, rsp_data, rsp_id, rsp_status}, 64'h0);
      reset = 1'b0;
   endtask

   int n;

   initial begin
      reset     = 1'b1;
      req       = '0;
      req_code  = {8'h43, 8'h42, 8'h41, 8'h40};
      alarm_clr = 1'b0;
      tx_busy   = 1'b0;
      rx_data   = '0;
      rx_rdy    = 1'b0;
      do_reset();

      // Single request, valid reply.
      req_code[7:0] = 8'h12;
      push_tx(8'h12, 4'b0001);
      push_rsp(2'd0, 8'h12, 2'd0);
      @(negedge clock);
      req = 4'b0001;
      wait_tx();
      req = '0;
      send_byte(8'h12);
      send_byte(8'h25);
      wait_rsp_done();
      req_code[7:0] = 8'h40;

      // Round-robin from a fresh pointer over held requests.
      do_reset();
      push_tx(8'h40, 4'b0001);
      push_tx(8'h41, 4'b0010);
      push_tx(8'h43, 4'b1000);
      push_tx(8'h40, 4'b0001);
      push_rsp(2'd0, 8'hA5, 2'd0);
      push_rsp(2'd1, 8'h01, 2'd0);
      push_rsp(2'd3, 8'hFF, 2'd0);
      push_rsp(2'd0, 8'h5A, 2'd0);
      @(negedge clock);
      req = 4'b1011;
      wait_tx(); send_byte(8'hA5); send_byte(8'h92);
      wait_tx(); send_byte(8'h01); send_byte(8'h36);
      wait_tx(); send_byte(8'hFF); send_byte(8'hC8);
      wait_tx(); req = '0; send_byte(8'h5A); send_byte(8'h6D);
      wait_rsp_done();

      // Corrupt replies exhaust the retries.
      push_tx(8'h42, 4'b0100);
      push_tx(8'h42, 4'b0000);
      push_tx(8'h42, 4'b0000);
      push_rsp(2'd2, 8'h00, 2'd2);
      @(negedge clock);
      req = 4'b0100;
      wait_tx(); req = '0; send_byte(8'h12); send_byte(8'h00);
      wait_tx(); send_byte(8'h12); send_byte(8'h00);
      wait_tx(); send_byte(8'h12); send_byte(8'h00);
      wait_rsp_done();
      check("tx_queue_after_badchk", exp_tx.size(), 0);

      // No reply: timeout latency, then a normal request behind tx_busy.
      push_tx(8'h41, 4'b0010);
      push_rsp(2'd1, 8'h00, 2'd1);
      @(negedge clock);
      req = 4'b0010;
      wait_tx();
      req = '0;
      n = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clock);
         #1;
         n++;
         if (rsp_valid) break;
      end
      check("timeout_latency", n, 256);
      wait_rsp_done();
      push_tx(8'h43, 4'b1000);
      push_rsp(2'd3, 8'h5A, 2'd0);
      @(negedge clock);
      tx_busy = 1'b1;
      req     = 4'b1000;
      repeat (3) @(negedge clock);
      check("no_write_while_busy", {tx_wr_en, grant}, 5'b0);
      tx_busy = 1'b0;
      wait_tx();
      req = '0;
      send_byte(8'h5A);
      send_byte(8'h6D);
      wait_rsp_done();

      // Alarm reply, clear, then unsolicited frames in IDLE.
      push_tx(8'h40, 4'b0001);
      push_rsp(2'd0, 8'h00, 2'd3);
      @(negedge clock);
      req = 4'b0001;
      wait_tx();
      req = '0;
      send_byte(8'h00);
      send_byte(8'h37);
      wait_rsp_done();
      repeat (3) @(negedge clock);
      check("alarm_sticky", alarm, 1'b1);
      alarm_clr = 1'b1;
      @(negedge clock);
      alarm_clr = 1'b0;
      check("alarm_cleared", alarm, 1'b0);
      send_byte(8'h00);
      send_byte(8'h00);
      @(negedge clock);
      check("alarm_bad_unsolicited", alarm, 1'b0);
      send_byte(8'h00);
      send_byte(8'h37);
      @(negedge clock);
      check("alarm_unsolicited", alarm, 1'b1);
      repeat (4) @(negedge clock);

      // Reset in the middle of a reply.
      push_tx(8'h41, 4'b0010);
      @(negedge clock);
      req = 4'b0010;
      wait_tx();
      req = '0;
      send_byte(8'h11);
      do_reset();
      repeat (300) @(negedge clock);
      check("no_rsp_after_reset", exp_rsp.size(), 0);
      push_tx(8'h40, 4'b0001);
      push_rsp(2'd0, 8'hA5, 2'd0);
      req = 4'b0001;
      wait_tx();
      req = '0;
      send_byte(8'hA5);
      send_byte(8'h92);
      wait_rsp_done();

      repeat (4) @(negedge clock);
      check("tx_queue_empty", exp_tx.size(), 0);
      check("rsp_queue_empty", exp_rsp.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_req_scheduler.md
# uart_req_scheduler

Sequences and shares the single Arduino UART link between up to N_REQ requesters (Nios custom-instruction port plus periodic pollers). It picks one requester round-robin, transmits its request byte, collects the two-byte reply (data, data ^ CHK_KEY) under a timeout, retries corrupted replies, and returns a tagged status. It sits between the requesters and the existing `uart` instance and owns its `din`/`wr_en`/`rdy_clr` controls.

## Interface
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 255, max cycles waited for each reply byte
- MAX_RETRY, 2, resends after a checksum failure before reporting BADCHK
- CHK_KEY, 8'h37, checksum XOR key

- clock  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high
- req  in  N_REQ  per-requester request level, held until granted
- req_code  in  8*N_REQ  request byte for requester i at [8i+7:8i]
- grant  out  N_REQ  one-hot, one-cycle pulse when requester's byte is written
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  $clog2(N_REQ)  requester the response belongs to
- rsp_data  out  8  reply data byte (0 unless status OK/ALARM)
- rsp_status  out  2  OK=0, TIMEOUT=1, BADCHK=2, ALARM=3
- alarm  out  1  sticky; set by any valid alarm frame
- alarm_clr  in  1  clears alarm
- tx_data  out  8  to uart din
- tx_wr_en  out  1  to uart wr_en, one-cycle pulse
- tx_busy  in  1  from uart
- rx_data  in  8  from uart dout
- rx_rdy  in  1  from uart rdy
- rx_rdy_clr  out  1  to uart rdy_clr, one-cycle pulse

## Operation
- Reset: all outputs 0, state IDLE, rr pointer = N_REQ-1 (requester 0 wins first), retry count 0, alarm 0.
- States: IDLE, SEND, RX0, RX1, CHECK, RESP.
- IDLE: if any req, select next requester after pointer (round-robin), latch its id/code, go SEND. Unsolicited bytes in IDLE are drained as frame pairs; valid frame with byte0 = 0x00 sets alarm, no rsp.
- SEND: wait while tx_busy; first cycle with tx_busy=0 assert tx_wr_en, tx_data=latched code, grant[id] (first attempt only), clear timer, go RX0. Pointer updates to id at grant.
- RX0/RX1: on rx_rdy capture rx_data as b0/b1, pulse rx_rdy_clr next cycle, clear timer, advance. Timer reaching TIMEOUT_CYCLES → RESP with TIMEOUT.
- CHECK: b1 != b0 ^ CHK_KEY → if retries < MAX_RETRY increment and go SEND, else RESP BADCHK. Valid and b0 = 0x00 → RESP ALARM, set alarm. Valid otherwise → RESP OK.
- RESP: rsp_valid=1 with id/data/status for one cycle, retry count 0, go IDLE.
- alarm: alarm_clr wins over a simultaneous set only if no set that cycle; set has priority.
- Bytes arriving during SEND are discarded (rx_rdy_clr pulsed).

## Timing
- req sampled in IDLE at cycle T → grant/tx_wr_en at T+1 earliest (tx_busy low).
- b1 captured at cycle N → CHECK N+1 → rsp_valid N+2.
- Timeout fires on cycle timer == TIMEOUT_CYCLES (counted from state entry or last byte); rsp_valid next cycle.
- One outstanding transaction; new grants only after RESP.
- Deasserting req after grant has no effect; before grant it cancels.
- reset mid-transaction: immediate return to IDLE, no rsp_valid, no pending rx_rdy_clr.

## Structure
- Package uart_link_pkg: status enum (OK, TIMEOUT, BADCHK, ALARM), state enum, CHK_KEY default, ALARM_CODE 8'h00.
- Sub-module rr_arbiter (req vector + pointer → one-hot grant, valid) instantiated once; rest in this module.

## Test plan
- req[0]=1 code 8'h12, reply 8'h12, 8'h25 → grant[0], tx_data 8'h12, rsp OK id 0 data 8'h12.
- req=4'b1011 held, all replies valid → grant order 0,1,3,0, rsp_ids match.
- Reply 8'h12, 8'h00 three times (MAX_RETRY=2) → three tx_wr_en, one rsp BADCHK data 0.
- No reply → rsp TIMEOUT exactly TIMEOUT_CYCLES+1 cycles after tx_wr_en; second request then served normally.
- Reply 8'h00, 8'h37 → rsp ALARM, alarm=1 until alarm_clr; unsolicited 8'h00,8'h37 in IDLE sets alarm, no rsp.
- Assert reset during RX1 → outputs 0, no rsp_valid, next request completes OK.
